io_bus_arbiter: RTL and testbench

//  Shares the single MMIO slot bus (cs/wr/rd/addr/wr_data/rd_data) feeding the
//  16-slot IO controller between N_MASTERS requesters (CPU, DMA, debug).

---
 rtl/io_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the MMIO slot bus between several masters.
// Each grant runs one three-cycle IDLE/ISSUE/ACK transaction; an optional lock is released after an idle timeout.
module io_bus_arbiter #(
    parameter int N_MASTERS    = 2,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_MASTERS-1:0]        m_req,
    input  logic [N_MASTERS-1:0]        m_wr,
    input  logic [N_MASTERS-1:0]        m_lock,
    input  logic [N_MASTERS-1:0][31:0]  m_addr,
    input  logic [N_MASTERS-1:0][31:0]  m_wdata,
    output logic [N_MASTERS-1:0]        m_gnt,
    output logic [N_MASTERS-1:0]        m_ack,
    output logic [31:0]                 m_rdata,
    output logic                        bus_cs,
    output logic                        bus_wr,
    output logic                        bus_rd,
    output logic [31:0]                 bus_addr,
    output logic [31:0]                 bus_wr_data,
    input  logic [31:0]                 bus_rd_data,
    output logic                        lock_active
);

    localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        sel_q, sel_d;
    logic [PW-1:0]        rr_q, rr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic                 lock_q, lock_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d;

    logic [N_MASTERS-1:0] cand;
    logic [N_MASTERS-1:0] selOneHot;
    logic [N_MASTERS-1:0] ownerOneHot;
    logic                 found;
    logic [PW-1:0]        win;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        if (int'(p) == N_MASTERS - 1)
            return '0;
        return p + PW'(1);
    endfunction

    assign selOneHot   = N_MASTERS'(1) << sel_q;
    assign ownerOneHot = N_MASTERS'(1) << owner_q;
    assign cand        = lock_q ? (m_req & ownerOneHot) : m_req;

    // Search starts at rr_q and wraps, so the first hit is the round-robin winner.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_MASTERS)
                idx = idx - N_MASTERS;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (lock_q && !m_req[owner_q]) begin
                    if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        lock_d = 1'b0;
                        cnt_d  = '0;
                        rr_d   = nextPtr(owner_q);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                if (found) begin
                    sel_d   = win;
                    state_d = ISSUE;
                    if (lock_q)
                        cnt_d = '0;
                end
            end
            ISSUE: begin
                state_d = ACK;
                if (!m_wr[sel_q])
                    rdata_d = bus_rd_data;
            end
            ACK: begin
                state_d = IDLE;
                cnt_d   = '0;
                // A locking master keeps the pointer so it stays first in line.
                if (m_lock[sel_q]) begin
                    lock_d  = 1'b1;
                    owner_d = sel_q;
                end else begin
                    lock_d = 1'b0;
                    rr_d   = nextPtr(sel_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_gnt       = '0;
        m_ack       = '0;
        bus_cs      = 1'b0;
        bus_wr      = 1'b0;
        bus_rd      = 1'b0;
        bus_addr    = '0;
        bus_wr_data = '0;
        case (state_q)
            ISSUE: begin
                m_gnt       = selOneHot;
                bus_cs      = 1'b1;
                bus_wr      = m_wr[sel_q];
                bus_rd      = ~m_wr[sel_q];
                bus_addr    = m_addr[sel_q];
                bus_wr_data = m_wdata[sel_q];
            end
            ACK: begin
                m_gnt = selOneHot;
                m_ack = selOneHot;
            end
            default: ;
        endcase
    end

    assign m_rdata     = rdata_q;
    assign lock_active = lock_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: stimulus queues expected transactions in grant order,
// a negedge monitor compares each bus cycle and each acknowledge against the queue head.
module tb_io_bus_arbiter;

    localparam int N = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       m_req;
    logic [N-1:0]       m_wr;
    logic [N-1:0]       m_lock;
    logic [N-1:0][31:0] m_addr;
    logic [N-1:0][31:0] m_wdata;
    logic [N-1:0]       m_gnt;
    logic [N-1:0]       m_ack;
    logic [31:0]        m_rdata;
    logic               bus_cs;
    logic               bus_wr;
    logic               bus_rd;
    logic [31:0]        bus_addr;
    logic [31:0]        bus_wr_data;
    logic [31:0]        bus_rd_data;
    logic               lock_active;
    logic [31:0]        rdVal;

    typedef struct {
        int          master;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monExp;
    int          ackCycles[$];
    int          checks      = 0;
    int          failures    = 0;
    int          cycleCount  = 0;
    int          lastCsCycle = -10;
    logic [31:0] modelRdata  = 32'd0;

    assign bus_rd_data = rdVal;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    io_bus_arbiter #(.N_MASTERS(N), .LOCK_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .m_req       (m_req),
        .m_wr        (m_wr),
        .m_lock      (m_lock),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_gnt       (m_gnt),
        .m_ack       (m_ack),
        .m_rdata     (m_rdata),
        .bus_cs      (bus_cs),
        .bus_wr      (bus_wr),
        .bus_rd      (bus_rd),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .lock_active (lock_active)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int m, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdv);
        exp_t e;
        if (!wr)
            modelRdata = rdv;
        e.master = m;
        e.wr     = wr;
        e.addr   = addr;
        e.wdata  = wdata;
        e.rdata  = modelRdata;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int m, input logic wr, input logic lock,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        m_wr[m]    = wr;
        m_lock[m]  = lock;
        m_addr[m]  = addr;
        m_wdata[m] = wdata;
        m_req[m]   = 1'b1;
    endtask

    task automatic stopReq(input int m);
        m_req[m]  = 1'b0;
        m_lock[m] = 1'b0;
    endtask

    // Returns one cycle after the acknowledge, i.e. in the following IDLE cycle.
    task automatic waitAck(input int m, output int ackCyc);
        ackCyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_ack[m]) begin
                ackCyc = cycleCount;
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        failures++;
        $display("[TB] FAIL ack_timeout: master %0d got no ack within 60 cycles", m);
    endtask

    task automatic doTxn(input int m, input logic wr, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata, output int ackCyc);
        applyStimulus(m, wr, lock, addr, wdata);
        waitAck(m, ackCyc);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus_cs) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_bus_cs", 32'(bus_cs), 32'd0);
                end else begin
                    monExp = expQ[0];
                    checkOutput("bus_wr", 32'(bus_wr), 32'(monExp.wr));
                    checkOutput("bus_rd", 32'(bus_rd), 32'(!monExp.wr));
                    checkOutput("bus_addr", bus_addr, monExp.addr);
                    checkOutput("bus_wr_data", bus_wr_data, monExp.wdata);
                    checkOutput("gnt_issue", 32'(m_gnt), 32'(1) << monExp.master);
                end
                lastCsCycle = cycleCount;
            end
            if (m_ack != '0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_ack", 32'(m_ack), 32'd0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("ack_master", 32'(m_ack), 32'(1) << monExp.master);
                    checkOutput("gnt_ack", 32'(m_gnt), 32'(1) << monExp.master);
                    checkOutput("m_rdata", m_rdata, monExp.rdata);
                    checkOutput("ack_after_cs", 32'(cycleCount - lastCsCycle), 32'd1);
                    checkOutput("bus_idle_in_ack",
                                bus_addr | bus_wr_data | 32'({bus_cs, bus_wr, bus_rd}), 32'd0);
                end
                ackCycles.push_back(cycleCount);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0;
        int a1;
        int ackCyc;
        int t;
        reset   = 1'b0;
        m_req   = '0;
        m_wr    = '0;
        m_lock  = '0;
        m_addr  = '0;
        m_wdata = '0;
        rdVal   = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_gnt", 32'(m_gnt), 32'd0);
        checkOutput("reset_ack", 32'(m_ack), 32'd0);
        checkOutput("reset_rdata", m_rdata, 32'd0);
        checkOutput("reset_bus_cs", 32'(bus_cs), 32'd0);
        checkOutput("reset_bus_addr", bus_addr, 32'd0);
        checkOutput("reset_lock", 32'(lock_active), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Two masters requesting back to back alternate, starting from master 0.
        rdVal = 32'h1111_2222;
        ackCycles.delete();
        pushExp(0, 1'b0, 32'h100, 32'h0, rdVal);
        pushExp(1, 1'b1, 32'h200, 32'hCAFE_0001, rdVal);
        pushExp(0, 1'b1, 32'h104, 32'hCAFE_0002, rdVal);
        pushExp(1, 1'b0, 32'h204, 32'h0, rdVal);
        fork
            begin
                doTxn(0, 1'b0, 1'b0, 32'h100, 32'h0, a0);
                doTxn(0, 1'b1, 1'b0, 32'h104, 32'hCAFE_0002, a0);
                stopReq(0);
            end
            begin
                doTxn(1, 1'b1, 1'b0, 32'h200, 32'hCAFE_0001, a1);
                doTxn(1, 1'b0, 1'b0, 32'h204, 32'h0, a1);
                stopReq(1);
            end
        join
        checkOutput("rr_ack_count", 32'(ackCycles.size()), 32'd4);
        for (int i = 0; i < 3; i++)
            if (ackCycles.size() > i + 1)
                checkOutput("rr_ack_spacing", 32'(ackCycles[i+1] - ackCycles[i]), 32'd3);
        checkOutput("rr_queue_drained", 32'(expQ.size()), 32'd0);

        rdVal = 32'hDEAD_BEEF;
        pushExp(0, 1'b0, 32'h0000_0084, 32'h0, rdVal);
        t = cycleCount;
        doTxn(0, 1'b0, 1'b0, 32'h0000_0084, 32'h0, ackCyc);
        stopReq(0);
        checkOutput("read_latency", 32'(ackCyc - t), 32'd2);
        checkOutput("read_rdata_held", m_rdata, 32'hDEAD_BEEF);

        rdVal = 32'hA5A5_5A5A;
        pushExp(0, 1'b1, 32'h10, 32'h1234_5678, rdVal);
        doTxn(0, 1'b1, 1'b0, 32'h10, 32'h1234_5678, ackCyc);
        stopReq(0);
        checkOutput("write_keeps_rdata", m_rdata, 32'hDEAD_BEEF);
        rdVal = 32'h0BAD_F00D;
        pushExp(0, 1'b0, 32'h14, 32'h0, rdVal);
        doTxn(0, 1'b0, 1'b0, 32'h14, 32'h0, ackCyc);
        stopReq(0);
        checkOutput("read_updates_rdata", m_rdata, 32'h0BAD_F00D);

        // Master 1 locks the bus; master 0 waits until the unlocking transaction.
        rdVal = 32'h3333_4444;
        pushExp(1, 1'b1, 32'h300, 32'hA0, rdVal);
        pushExp(1, 1'b1, 32'h304, 32'hA1, rdVal);
        pushExp(1, 1'b0, 32'h308, 32'h0, rdVal);
        pushExp(1, 1'b1, 32'h30C, 32'hA3, rdVal);
        pushExp(0, 1'b0, 32'h400, 32'h0, rdVal);
        fork
            begin
                doTxn(1, 1'b1, 1'b1, 32'h300, 32'hA0, a1);
                checkOutput("lock_active_set", 32'(lock_active), 32'd1);
                doTxn(1, 1'b1, 1'b1, 32'h304, 32'hA1, a1);
                doTxn(1, 1'b0, 1'b1, 32'h308, 32'h0, a1);
                checkOutput("lock_active_held", 32'(lock_active), 32'd1);
                doTxn(1, 1'b1, 1'b0, 32'h30C, 32'hA3, a1);
                checkOutput("lock_released", 32'(lock_active), 32'd0);
                stopReq(1);
            end
            begin
                @(posedge clk);
                #1;
                doTxn(0, 1'b0, 1'b0, 32'h400, 32'h0, a0);
                stopReq(0);
            end
        join
        checkOutput("lock_queue_drained", 32'(expQ.size()), 32'd0);

        // Owner goes idle holding the lock; the timeout hands the bus to master 0.
        rdVal = 32'h6666_7777;
        pushExp(1, 1'b1, 32'h500, 32'h55, rdVal);
        pushExp(0, 1'b0, 32'h600, 32'h0, rdVal);
        doTxn(1, 1'b1, 1'b1, 32'h500, 32'h55, a1);
        stopReq(1);
        applyStimulus(0, 1'b0, 1'b0, 32'h600, 32'h0);
        t = cycleCount;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        checkOutput("lock_before_timeout", 32'(lock_active), 32'd1);
        checkOutput("no_gnt_during_lock", 32'(m_gnt), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lock_timeout_release", 32'(lock_active), 32'd0);
        waitAck(0, ackCyc);
        stopReq(0);
        checkOutput("timeout_grant_latency", 32'(ackCyc - t), 32'd18);

        // Reset asserted mid-ISSUE abandons the transaction.
        rdVal = 32'h7777_8888;
        applyStimulus(0, 1'b0, 1'b0, 32'h700, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("issue_before_reset", 32'(bus_cs), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset_drops_cs", 32'(bus_cs), 32'd0);
        checkOutput("reset_drops_rd", 32'(bus_rd), 32'd0);
        checkOutput("reset_drops_addr", bus_addr, 32'd0);
        checkOutput("reset_drops_gnt", 32'(m_gnt), 32'd0);
        checkOutput("reset_clears_rdata", m_rdata, 32'd0);
        checkOutput("reset_clears_ack", 32'(m_ack), 32'd0);
        stopReq(0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("no_ack_after_reset", 32'(m_ack), 32'd0);
        checkOutput("idle_after_reset", 32'(bus_cs), 32'd0);

        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
